// File: rtl/m_axis_pixel_tx.sv
// Pixel stream to AXI-Stream master: buffers 24-bit pixels, packs them into 32-bit beats, frames them with TLAST.
// Latency: two cycles from an accepted pixel to TVALID when idle; backpressure is !full with no same-cycle pop bypass.
module m_axis_pixel_tx #(
    parameter int FRAME_BEATS = 960,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_last,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tstrb,
    output logic        m_axis_tlast,
    output logic        frame_done,
    output logic        busy
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [10:0]     LAST_BEAT = 11'(FRAME_BEATS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        r_state;
    logic [24:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [10:0]   r_beat_cnt;
    logic          r_frame_done;

    logic          w_empty;
    logic          w_full;
    logic [24:0]   w_head;
    logic          w_tvalid;
    logic          w_tlast;
    logic          w_push;
    logic          w_pop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_head   = r_mem[r_rd_ptr];
    assign w_tvalid = (r_state == STREAM) && !w_empty;
    // Beat counter forces TLAST when the source never supplies in_last.
    assign w_tlast  = w_tvalid && (w_head[24] || (r_beat_cnt == LAST_BEAT));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_tvalid && m_axis_tready;

    assign in_ready      = !rst && !w_full;
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tdata  = w_tvalid ? {8'h00, w_head[23:0]} : 32'h0;
    assign m_axis_tstrb  = 4'hF;
    assign m_axis_tlast  = w_tlast;
    assign frame_done    = r_frame_done;
    assign busy          = (r_state == STREAM) || !w_empty;

    // Storage is not reset; stale entries are never visible because outputs gate on occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_beat_cnt   <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            r_frame_done <= w_pop && w_tlast;

            if (w_pop) begin
                r_beat_cnt <= w_tlast ? 11'd0 : r_beat_cnt + 11'd1;
            end

            // Every frame end drops to IDLE, giving at most one bubble between frames.
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_pop && w_tlast) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
